// File: rtl/pipe_hazard_forward_unit.sv
// Combined hazard/forward controller for the 5-stage MIPS pipeline: tracks in-flight
// destinations per stage, forwards EX operands, stalls on load-use and flushes on branches.
module pipe_hazard_forward_unit #(
    parameter int RA_W       = 5,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_STALL = 1,
    parameter int BR_STAGE   = 1,
    parameter int CNT_W      = 16,
    localparam int FS_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [RA_W-1:0]     id_rs,
    input  logic [RA_W-1:0]     id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [RA_W-1:0]     id_rd,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                stall,
    output logic [BR_STAGE+1:0] flush_mask,
    output logic [FS_W-1:0]     fwd_a,
    output logic [FS_W-1:0]     fwd_b,
    output logic [CNT_W-1:0]    stall_events
);
    localparam int CW = (LOAD_STALL > 2) ? $clog2(LOAD_STALL - 1) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'((LOAD_STALL > 1) ? LOAD_STALL - 2 : 0);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_STALL = 1'b1;

    logic [FWD_STAGES:0] sb_valid_reg;
    logic [FWD_STAGES:0] sb_wr_reg;
    logic [FWD_STAGES:0] sb_ld_reg;
    logic [RA_W-1:0]     sb_rd_reg [FWD_STAGES+1];
    logic [RA_W-1:0]     ex_rs_reg;
    logic [RA_W-1:0]     ex_rt_reg;
    logic                ex_use_rs_reg;
    logic                ex_use_rt_reg;
    logic [0:0]          state_reg;
    logic [CW-1:0]       cnt_reg;
    logic [CNT_W-1:0]    events_reg;

    logic                haz;
    logic                stall_int;
    logic [FWD_STAGES:1] match_a;
    logic [FWD_STAGES:1] match_b;
    logic [FS_W-1:0]     fwd_a_next;
    logic [FS_W-1:0]     fwd_b_next;

    // A load in stage 0 has no data yet; the ID consumer must wait.
    assign haz = id_valid & sb_valid_reg[0] & sb_ld_reg[0] & sb_wr_reg[0] &
                 (sb_rd_reg[0] != '0) &
                 ((id_use_rs & (sb_rd_reg[0] == id_rs)) | (id_use_rt & (sb_rd_reg[0] == id_rt)));

    assign stall_int = !reset && !branch_taken && ((state_reg == ST_STALL) || haz);

    // Per-stage producer match; loads only forward once they are past the stall window.
    generate
        for (genvar gi = 1; gi <= FWD_STAGES; gi++) begin : g_match
            logic ld_ok;
            assign ld_ok = (gi > LOAD_STALL) ? 1'b1 : !sb_ld_reg[gi];
            assign match_a[gi] = sb_valid_reg[gi] & sb_wr_reg[gi] & ld_ok & ex_use_rs_reg &
                                 (sb_rd_reg[gi] == ex_rs_reg) & (sb_rd_reg[gi] != '0);
            assign match_b[gi] = sb_valid_reg[gi] & sb_wr_reg[gi] & ld_ok & ex_use_rt_reg &
                                 (sb_rd_reg[gi] == ex_rt_reg) & (sb_rd_reg[gi] != '0);
        end
    endgenerate

    always_comb begin
        fwd_a_next = '0;
        fwd_b_next = '0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (match_a[k]) fwd_a_next = FS_W'(k);
            if (match_b[k]) fwd_b_next = FS_W'(k);
        end
    end

    assign fwd_a        = (reset || !sb_valid_reg[0]) ? '0 : fwd_a_next;
    assign fwd_b        = (reset || !sb_valid_reg[0]) ? '0 : fwd_b_next;
    assign stall        = stall_int;
    assign pc_write     = !stall_int;
    assign if_id_write  = !stall_int;
    assign flush_mask   = {(BR_STAGE + 2){branch_taken & !reset}};
    assign stall_events = events_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_valid_reg <= '0;
        end else begin
            sb_valid_reg[0] <= id_valid && !stall_int && !branch_taken;
            for (int s = 1; s <= FWD_STAGES; s++)
                sb_valid_reg[s] <= sb_valid_reg[s-1] && !(branch_taken && (s <= BR_STAGE));
        end
        sb_wr_reg[0]  <= id_reg_write;
        sb_ld_reg[0]  <= id_mem_read;
        sb_rd_reg[0]  <= id_rd;
        ex_rs_reg     <= id_rs;
        ex_rt_reg     <= id_rt;
        ex_use_rs_reg <= id_use_rs;
        ex_use_rt_reg <= id_use_rt;
        for (int s = 1; s <= FWD_STAGES; s++) begin
            sb_wr_reg[s] <= sb_wr_reg[s-1];
            sb_ld_reg[s] <= sb_ld_reg[s-1];
            sb_rd_reg[s] <= sb_rd_reg[s-1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || branch_taken) begin
            state_reg <= ST_RUN;
            cnt_reg   <= '0;
        end else if (state_reg == ST_RUN) begin
            if (haz && (LOAD_STALL > 1)) begin
                state_reg <= ST_STALL;
                cnt_reg   <= CNT_INIT;
            end
        end else if (cnt_reg == '0) begin
            state_reg <= ST_RUN;
        end else begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            events_reg <= '0;
        else if (stall_int && (events_reg != '1))
            events_reg <= events_reg + 1'b1;
    end
endmodule

// File: tb/tb_pipe_hazard_forward_unit.sv
// Randomised scoreboard bench: two configurations share stimulus; an instruction-level
// pipeline model predicts each cycle's outputs, a monitor compares them at negedge.
module tb_pipe_hazard_forward_unit;
    localparam int FS0 = 2, LS0 = 1, BR0 = 1, CW0 = 16;
    localparam int FS1 = 3, LS1 = 2, BR1 = 2, CW1 = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, id_valid, id_use_rs, id_use_rt, id_reg_write, id_mem_read, branch_taken;
    logic [4:0] id_rs, id_rt, id_rd;

    logic       pcw0, ifw0, st0, pcw1, ifw1, st1;
    logic [2:0] fm0;
    logic [3:0] fm1;
    logic [1:0] fa0, fb0, fa1, fb1;
    logic [15:0] ev0;
    logic [3:0]  ev1;

    pipe_hazard_forward_unit #(.RA_W(5), .FWD_STAGES(FS0), .LOAD_STALL(LS0), .BR_STAGE(BR0), .CNT_W(CW0)) u0 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .branch_taken(branch_taken), .pc_write(pcw0), .if_id_write(ifw0),
        .stall(st0), .flush_mask(fm0), .fwd_a(fa0), .fwd_b(fb0), .stall_events(ev0));

    pipe_hazard_forward_unit #(.RA_W(5), .FWD_STAGES(FS1), .LOAD_STALL(LS1), .BR_STAGE(BR1), .CNT_W(CW1)) u1 (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .branch_taken(branch_taken), .pc_write(pcw1), .if_id_write(ifw1),
        .stall(st1), .flush_mask(fm1), .fwd_a(fa1), .fwd_b(fb1), .stall_events(ev1));

    typedef struct {
        logic v; logic [4:0] rd; logic wr; logic ld;
        logic [4:0] rs; logic [4:0] rt; logic urs; logic urt;
    } instr_t;
    typedef struct {
        logic stall; logic pcw; logic [3:0] flush; logic [1:0] fa; logic [1:0] fb; logic [15:0] ev;
    } exp_t;

    instr_t pipe [2][4];
    int     stall_left [2];
    int     events [2];
    logic   m_stall [2];
    logic   m_haz [2];
    exp_t   q0 [$];
    exp_t   q1 [$];
    int     passed = 0;
    int     total  = 0;

    function automatic int fs_of(int m); return (m == 0) ? FS0 : FS1; endfunction
    function automatic int ls_of(int m); return (m == 0) ? LS0 : LS1; endfunction
    function automatic int br_of(int m); return (m == 0) ? BR0 : BR1; endfunction
    function automatic int cw_of(int m); return (m == 0) ? CW0 : CW1; endfunction

    // Youngest in-flight writer of r whose result is already available.
    function automatic logic [1:0] ref_fwd(int m, logic [4:0] r, logic u);
        if (!pipe[m][0].v || !u || r == 5'd0) return 2'd0;
        for (int k = 1; k <= fs_of(m); k++)
            if (pipe[m][k].v && pipe[m][k].wr && pipe[m][k].rd == r && (!pipe[m][k].ld || k > ls_of(m)))
                return 2'(k);
        return 2'd0;
    endfunction

    function automatic logic ref_haz(int m);
        instr_t p;
        p = pipe[m][0];
        return id_valid && p.v && p.ld && p.wr && p.rd != 5'd0 &&
               ((id_use_rs && p.rd == id_rs) || (id_use_rt && p.rd == id_rt));
    endfunction

    task automatic expect_cycle();
        for (int m = 0; m < 2; m++) begin
            exp_t e;
            e.ev = 16'(events[m]);
            if (reset) begin
                m_haz[m] = 1'b0; m_stall[m] = 1'b0;
                e.stall = 1'b0; e.pcw = 1'b1; e.flush = 4'd0; e.fa = 2'd0; e.fb = 2'd0;
            end else begin
                m_haz[m]   = ref_haz(m);
                m_stall[m] = !branch_taken && (stall_left[m] > 0 || m_haz[m]);
                e.stall = m_stall[m];
                e.pcw   = !m_stall[m];
                e.flush = branch_taken ? 4'((1 << (br_of(m) + 2)) - 1) : 4'd0;
                e.fa    = ref_fwd(m, pipe[m][0].rs, pipe[m][0].urs);
                e.fb    = ref_fwd(m, pipe[m][0].rt, pipe[m][0].urt);
            end
            if (m == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic advance();
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                for (int s = 0; s < 4; s++) pipe[m][s].v = 1'b0;
                stall_left[m] = 0;
                events[m] = 0;
            end else begin
                if (m_stall[m]) begin
                    events[m] = events[m] + 1;
                    if (events[m] > (1 << cw_of(m)) - 1) events[m] = (1 << cw_of(m)) - 1;
                end
                for (int s = fs_of(m); s >= 1; s--) pipe[m][s] = pipe[m][s-1];
                if (branch_taken)
                    for (int s = 1; s <= br_of(m); s++) pipe[m][s].v = 1'b0;
                pipe[m][0] = '{v: id_valid && !m_stall[m] && !branch_taken, rd: id_rd, wr: id_reg_write,
                               ld: id_mem_read, rs: id_rs, rt: id_rt, urs: id_use_rs, urt: id_use_rt};
                if (branch_taken)           stall_left[m] = 0;
                else if (stall_left[m] > 0) stall_left[m] = stall_left[m] - 1;
                else if (m_haz[m])          stall_left[m] = ls_of(m) - 1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic br, input logic v, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt, input logic [4:0] rd,
                        input logic wr, input logic ld);
        @(posedge clock);
        #1;
        advance();
        reset = rst; branch_taken = br; id_valid = v; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt; id_rd = rd; id_reg_write = wr; id_mem_read = ld;
        expect_cycle();
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("u0.stall", 16'(st0), 16'(e.stall));
            check("u0.pc_write", 16'(pcw0), 16'(e.pcw));
            check("u0.if_id_write", 16'(ifw0), 16'(e.pcw));
            check("u0.flush_mask", 16'(fm0), 16'(e.flush));
            check("u0.fwd_a", 16'(fa0), 16'(e.fa));
            check("u0.fwd_b", 16'(fb0), 16'(e.fb));
            check("u0.stall_events", ev0, e.ev);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("u1.stall", 16'(st1), 16'(e.stall));
            check("u1.pc_write", 16'(pcw1), 16'(e.pcw));
            check("u1.if_id_write", 16'(ifw1), 16'(e.pcw));
            check("u1.flush_mask", 16'(fm1), 16'(e.flush));
            check("u1.fwd_a", 16'(fa1), 16'(e.fa));
            check("u1.fwd_b", 16'(fb1), 16'(e.fb));
            check("u1.stall_events", 16'(ev1), e.ev);
        end
    end

    initial begin
        for (int m = 0; m < 2; m++) begin
            for (int s = 0; s < 4; s++) pipe[m][s] = '{default: '0};
            stall_left[m] = 0; events[m] = 0;
        end
        reset = 1'b1; branch_taken = 1'b1; id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2;
        id_use_rs = 1'b1; id_use_rt = 1'b1; id_rd = 5'd3; id_reg_write = 1'b1; id_mem_read = 1'b1;
        // second reset cycle with branch_taken held high
        step(1, 1, 1, 1, 2, 1, 1, 3, 1, 1);
        //   rst br v  rs rt urs urt rd wr ld
        step(0, 0, 1, 1, 2, 1, 1, 3, 1, 0);   // add $3,$1,$2
        step(0, 0, 1, 3, 1, 1, 1, 4, 1, 0);   // sub $4,$3,$1
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 2, 1, 1, 3, 1, 0);   // add $3
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // nop
        step(0, 0, 1, 3, 1, 1, 1, 4, 1, 0);   // sub $4,$3,$1
        step(0, 0, 1, 1, 2, 1, 1, 0, 1, 0);   // add $0
        step(0, 0, 1, 0, 1, 1, 1, 4, 1, 0);   // sub $4,$0,$1
        step(0, 0, 1, 1, 2, 1, 1, 3, 1, 0);   // add $3
        step(0, 0, 1, 2, 1, 1, 1, 3, 1, 0);   // add $3
        step(0, 0, 1, 3, 3, 1, 1, 5, 1, 0);   // or $5,$3,$3
        step(0, 0, 1, 1, 0, 1, 0, 5, 1, 1);   // lw $5
        repeat (3) step(0, 0, 1, 5, 2, 1, 1, 6, 1, 0);   // add $6,$5,$2 held in ID
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 1, 0, 5, 1, 1);   // lw $5
        step(0, 1, 1, 5, 2, 1, 1, 6, 1, 0);   // branch in detection cycle
        step(0, 0, 1, 1, 0, 1, 0, 5, 1, 1);   // lw $5
        step(0, 0, 1, 5, 2, 1, 1, 6, 1, 0);   // hazard detected
        step(1, 0, 1, 5, 2, 1, 1, 6, 1, 0);   // reset while u1 is in its extra stall cycle
        step(0, 0, 1, 5, 2, 1, 1, 6, 1, 0);
        repeat (20) step(0, 0, 1, 5, 5, 1, 1, 5, 1, 1);   // back-to-back lw $5 chain
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 85,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 60, 5'($urandom_range(0, 3)), $urandom_range(0, 99) < 75,
                 $urandom_range(0, 99) < 35);
        end
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (q0.size() == 0 && q1.size() == 0) passed++;
        else $display("FAIL drain: got %0d/%0d queued expected 0/0", q0.size(), q1.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
